// File: rtl/tag_ram_assoc.sv
// rtl/tag_ram_assoc.sv - N-way set-associative tag store with invalidate-all sequencer (optional TAG_RAM_DIRTY_EN)
module tag_ram_assoc #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INDEX_WIDTH = 10,
    parameter int WAYS        = 2,
    localparam int TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH,
    localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  LookupValid,
    input  logic [ADDR_WIDTH-1:0] LookupAddr,
    output logic                  LookupDone,
    output logic                  Hit,
    output logic [WAY_W-1:0]      HitWay,
    output logic [WAY_W-1:0]      VictimWay,
    input  logic                  FillValid,
    input  logic [ADDR_WIDTH-1:0] FillAddr,
    input  logic [WAY_W-1:0]      FillWay,
`ifdef TAG_RAM_DIRTY_EN
    input  logic                  FillDirty,
    input  logic                  MarkDirty,
    input  logic [WAY_W-1:0]      MarkWay,
    output logic                  VictimDirty,
    output logic [TAG_WIDTH-1:0]  VictimTag,
`endif
    input  logic                  Flush,
    output logic                  Busy
);

    localparam int SETS = 1 << INDEX_WIDTH;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [INDEX_WIDTH-1:0]  flush_cnt;

    logic [WAYS-1:0][TAG_WIDTH-1:0] tag_mem   [SETS];
    logic [WAYS-1:0]                valid_mem [SETS];
    logic [WAY_W-1:0]               rr_ptr    [SETS];

    logic                   idle;
    logic                   lookup_acc;
    logic                   fill_acc;
    logic [INDEX_WIDTH-1:0] lk_index;
    logic [TAG_WIDTH-1:0]   lk_tag;
    logic [INDEX_WIDTH-1:0] fl_index;
    logic [TAG_WIDTH-1:0]   fl_tag;

    logic [WAYS-1:0][TAG_WIDTH-1:0] rd_tags;
    logic [WAYS-1:0]                rd_valid;
    logic [WAY_W-1:0]               rd_ptr;
    logic [WAY_W-1:0]               fill_ptr;
    logic [WAY_W-1:0]               fill_ptr_next;

    logic             hit_c;
    logic [WAY_W-1:0] hit_way_c;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] victim_c;

    assign idle       = (state == IDLE);
    assign Busy       = (state == FLUSH);
    assign lookup_acc = LookupValid & idle;
    assign fill_acc   = FillValid & idle;

    assign lk_index = LookupAddr[INDEX_WIDTH-1:0];
    assign lk_tag   = LookupAddr[ADDR_WIDTH-1:INDEX_WIDTH];
    assign fl_index = FillAddr[INDEX_WIDTH-1:0];
    assign fl_tag   = FillAddr[ADDR_WIDTH-1:INDEX_WIDTH];

    assign rd_tags  = tag_mem[lk_index];
    assign rd_valid = valid_mem[lk_index];
    assign rd_ptr   = rr_ptr[lk_index];

    assign fill_ptr      = rr_ptr[fl_index];
    assign fill_ptr_next = (WAYS == 1) ? '0 : fill_ptr + WAY_W'(1);

    // Descending scan so the last assignment wins: lowest matching / lowest invalid way.
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (rd_valid[w] && (rd_tags[w] == lk_tag)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
            if (!rd_valid[w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim_c = inv_found ? inv_way : rd_ptr;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state     <= FLUSH;
            flush_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == FLUSH) begin
                flush_cnt <= flush_cnt + INDEX_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Flush) state_next = FLUSH;
            FLUSH:   if (&flush_cnt) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                rr_ptr[s]    <= '0;
            end
        end else if (state == FLUSH) begin
            valid_mem[flush_cnt] <= '0;
            rr_ptr[flush_cnt]    <= '0;
        end else if (fill_acc) begin
            valid_mem[fl_index][FillWay] <= 1'b1;
            if (FillWay == fill_ptr) begin
                rr_ptr[fl_index] <= fill_ptr_next;
            end
        end
    end

    // Tags carry no reset; a tag is only meaningful once its valid bit is set.
    always_ff @(posedge Clk) begin
        if (fill_acc) begin
            tag_mem[fl_index][FillWay] <= fl_tag;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            LookupDone <= 1'b0;
            Hit        <= 1'b0;
            HitWay     <= '0;
            VictimWay  <= '0;
        end else begin
            LookupDone <= lookup_acc;
            if (lookup_acc) begin
                Hit       <= hit_c;
                HitWay    <= hit_way_c;
                VictimWay <= victim_c;
            end
        end
    end

`ifdef TAG_RAM_DIRTY_EN
    logic [WAYS-1:0] dirty_mem [SETS];
    logic [WAYS-1:0] rd_dirty;

    assign rd_dirty = dirty_mem[lk_index];

    // A fill to the same way as a mark in the same cycle takes precedence.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                dirty_mem[s] <= '0;
            end
        end else if (state == FLUSH) begin
            dirty_mem[flush_cnt] <= '0;
        end else begin
            if (MarkDirty) begin
                dirty_mem[lk_index][MarkWay] <= 1'b1;
            end
            if (FillValid) begin
                dirty_mem[fl_index][FillWay] <= FillDirty;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            VictimDirty <= 1'b0;
            VictimTag   <= '0;
        end else if (lookup_acc) begin
            VictimDirty <= !inv_found && rd_dirty[victim_c];
            VictimTag   <= inv_found ? '0 : rd_tags[victim_c];
        end
    end
`endif

endmodule
